// File: rtl/rx_fcs_strip.sv
// ---------------------------------------------------------------------------
// rx_fcs_strip
//
// Receive-path stage fed by the RX FIFO read port. It checks the CRC-32 of
// every frame, removes the trailing 4-byte FCS, and marks the final payload
// byte of a bad frame (CRC mismatch or runt). Frames of four bytes or fewer
// produce no payload and only a status pulse.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   s_valid/s_ready input byte handshake; s_data byte, s_last = last FCS byte
//   m_valid/m_ready output byte handshake; m_data payload byte,
//                   m_last = final payload byte, m_err = frame bad (on m_last)
//   stat_ok         one-cycle pulse: good frame completed
//   stat_crc_err    one-cycle pulse: CRC mismatch
//   stat_runt       one-cycle pulse: frame shorter than MIN_FRAME
// ---------------------------------------------------------------------------
module rx_fcs_strip #(
    parameter int unsigned MIN_FRAME = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_err,
    output logic       stat_ok,
    output logic       stat_crc_err,
    output logic       stat_runt
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    // Register value left after a frame whose FCS matches its contents.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [16:0] MIN_LEN     = 17'(MIN_FRAME);

    // One byte of reflected CRC-32, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Four-byte delay line: entry 0 is the oldest byte. Whatever is still in
    // it when s_last arrives is the FCS and is simply abandoned.
    logic [7:0]  dly_q [4];
    logic [7:0]  dly_d [4];
    logic [2:0]  fill_q, fill_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;

    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q,  m_data_d;
    logic        m_last_q,  m_last_d;
    logic        m_err_q,   m_err_d;
    logic        stat_ok_q, stat_ok_d;
    logic        stat_crc_err_q, stat_crc_err_d;
    logic        stat_runt_q, stat_runt_d;

    logic        accept;
    logic        pop;
    logic [31:0] crc_next;
    logic [16:0] len_next;
    logic        crc_bad;
    logic        runt;

    always_comb begin
        // NOTE: every signal gets a default at the top of the block so no
        // path leaves it unassigned and no latch is inferred.
        dly_d          = dly_q;
        fill_d         = fill_q;
        crc_d          = crc_q;
        len_d          = len_q;
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;
        m_last_d       = m_last_q;
        m_err_d        = m_err_q;

        // A full delay line can only take a byte if the output register is
        // free or being drained this cycle.
        s_ready  = (fill_q < 3'd4) || !m_valid_q || m_ready;
        accept   = s_valid && s_ready;
        pop      = accept && (fill_q == 3'd4);

        crc_next = crc_byte(crc_q, s_data);
        crc_bad  = (crc_next != CRC_RESIDUE);
        // 17 bits so a saturated counter still compares correctly.
        len_next = {1'b0, len_q} + 17'd1;
        runt     = (len_next < MIN_LEN);

        if (accept) begin
            if (pop) begin
                dly_d[0] = dly_q[1];
                dly_d[1] = dly_q[2];
                dly_d[2] = dly_q[3];
                dly_d[3] = s_data;
            end else begin
                dly_d[fill_q[1:0]] = s_data;
                fill_d             = fill_q + 3'd1;
            end
            crc_d = crc_next;
            len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
            if (s_last) begin
                fill_d = 3'd0;
                crc_d  = CRC_INIT;
                len_d  = 16'd0;
            end
        end

        if (pop) begin
            m_valid_d = 1'b1;
            m_data_d  = dly_q[0];
            m_last_d  = s_last;
            m_err_d   = s_last && (crc_bad || runt);
        end else if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_err_d   = 1'b0;
        end

        // Pulses fire once per s_last accept, so a stalled m_last beat
        // never repeats them.
        stat_ok_d      = accept && s_last && !crc_bad && !runt;
        stat_crc_err_d = accept && s_last && crc_bad;
        stat_runt_d    = accept && s_last && runt;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            fill_q         <= 3'd0;
            crc_q          <= CRC_INIT;
            len_q          <= 16'd0;
            m_valid_q      <= 1'b0;
            m_data_q       <= 8'h00;
            m_last_q       <= 1'b0;
            m_err_q        <= 1'b0;
            stat_ok_q      <= 1'b0;
            stat_crc_err_q <= 1'b0;
            stat_runt_q    <= 1'b0;
        end else begin
            fill_q         <= fill_d;
            crc_q          <= crc_d;
            len_q          <= len_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            m_last_q       <= m_last_d;
            m_err_q        <= m_err_d;
            stat_ok_q      <= stat_ok_d;
            stat_crc_err_q <= stat_crc_err_d;
            stat_runt_q    <= stat_runt_d;
        end
    end

    // NOTE: the delay-line storage has no reset; fill_q says which entries
    // are meaningful, so clearing the bytes would only add reset fan-out.
    always_ff @(posedge clk) begin
        dly_q <= dly_d;
    end

    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_last       = m_last_q;
    assign m_err        = m_err_q;
    assign stat_ok      = stat_ok_q;
    assign stat_crc_err = stat_crc_err_q;
    assign stat_runt    = stat_runt_q;

endmodule

// File: tb/tb_rx_fcs_strip.sv
// ---------------------------------------------------------------------------
// tb_rx_fcs_strip
//
// Self-checking bench for rx_fcs_strip: a cycle-level vector table for the
// handshake and reset corners, directed frame sequences, and randomized
// frames scored against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_rx_fcs_strip;

    localparam int MIN = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_err;
    logic       stat_ok;
    logic       stat_crc_err;
    logic       stat_runt;

    rx_fcs_strip #(.MIN_FRAME(MIN)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_err        (m_err),
        .stat_ok      (stat_ok),
        .stat_crc_err (stat_crc_err),
        .stat_runt    (stat_runt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // m_ready source: 0 always high, 1 toggling, 2 random, 3 from vector table
    int   mr_mode = 3;
    logic tbl_mr  = 1'b1;
    logic mr_gen  = 1'b1;
    assign m_ready = (mr_mode == 3) ? tbl_mr : mr_gen;

    always @(negedge clk) begin
        case (mr_mode)
            1:       mr_gen = cyc[0];
            2:       mr_gen = ($urandom_range(0, 3) != 0);
            default: mr_gen = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Reference model: table-driven CRC-32 and frame-level expectations
    // ------------------------------------------------------------------
    logic [31:0] crc_tab [256];
    logic [7:0]  frm [$];
    logic [9:0]  exp_q [$];   // {data, last, err}
    logic [2:0]  exp_st [$];  // {ok, crc_err, runt}

    function automatic logic [31:0] crc_run(input logic [31:0] r, input logic [7:0] b);
        return (r >> 8) ^ crc_tab[r[7:0] ^ b];
    endfunction

    // Payload of plen bytes (incrementing or random) followed by its FCS.
    task automatic build_frame(input int plen, input bit rnd);
        logic [31:0] r;
        logic [31:0] fcs;
        logic [7:0]  b;
        frm.delete();
        r = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            frm.push_back(b);
            r = crc_run(r, b);
        end
        fcs = ~r;
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    endtask

    task automatic model_frame();
        int          n;
        logic [31:0] r;
        logic        bad;
        logic        short_len;
        n = frm.size();
        r = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) r = crc_run(r, frm[i]);
        bad       = (r != 32'hDEBB20E3);
        short_len = (n < MIN);
        for (int i = 0; i < n - 4; i++)
            exp_q.push_back({frm[i], (i == n - 5), (i == n - 5) && (bad || short_len)});
        exp_st.push_back({!bad && !short_len, bad, short_len});
    endtask

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    int accept5_cyc = 0;

    task automatic send_byte(input logic [7:0] d, input logic l, input bit gaps, input int idx);
        int budget;
        bit fired;
        budget = 0;
        fired  = 0;
        @(negedge clk);
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!fired) begin
            #1;
            fired = s_ready;
            if (!fired) begin
                budget++;
                if (budget > 200) begin
                    check("s_ready_timeout", 32'(s_ready), 32'd1);
                    s_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        if (idx == 4) accept5_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic send_frame(input bit gaps);
        model_frame();
        for (int i = 0; i < frm.size(); i++)
            send_byte(frm[i], (i == frm.size() - 1), gaps, i);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        while ((exp_q.size() != 0 || exp_st.size() != 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        check("drain_beats_left", 32'(exp_q.size()), 32'd0);
        check("drain_stats_left", 32'(exp_st.size()), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: beats, status pulses, stall stability, latency capture
    // ------------------------------------------------------------------
    bit         mon_en = 0;
    bit         prev_stall = 0;
    logic [9:0] prev_beat = '0;
    bit         first_pending = 0;
    int         first_valid_cyc = 0;
    int         ok_count = 0;

    always begin
        @(negedge clk);
        #2;
        if (rst || !mon_en) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_hold", 32'({m_data, m_last, m_err}), 32'(prev_beat));
            end
            if (first_pending && m_valid) begin
                first_valid_cyc = cyc;
                first_pending   = 0;
            end
            if (m_valid && m_last && !prev_stall)
                check("stat_with_last", 32'(stat_ok | stat_crc_err | stat_runt), 32'd1);
            if (stat_ok || stat_crc_err || stat_runt) begin
                if (stat_ok) ok_count++;
                if (exp_st.size() == 0)
                    check("stat_unexpected", 32'({stat_ok, stat_crc_err, stat_runt}), 32'd0);
                else
                    check("stat_flags", 32'({stat_ok, stat_crc_err, stat_runt}), 32'(exp_st.pop_front()));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0)
                    check("beat_unexpected", 32'(m_valid), 32'd0);
                else
                    check("beat", 32'({m_data, m_last, m_err}), 32'(exp_q.pop_front()));
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_data, m_last, m_err};
        end
    end

    // ------------------------------------------------------------------
    // Cycle vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       mr;
        logic       e_sr;
        logic       e_mv;
        logic [7:0] e_md;
        logic       e_ml;
        logic       e_me;
        logic       e_ok;
        logic       e_runt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic sv, input logic [7:0] sd,
                                input logic sl, input logic mr, input logic e_sr,
                                input logic e_mv, input logic [7:0] e_md, input logic e_ml,
                                input logic e_me, input logic e_ok, input logic e_runt);
        vec_t v;
        v.rst = r;  v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml;
        v.e_me = e_me; v.e_ok = e_ok; v.e_runt = e_runt;
        return v;
    endfunction

    vec_t vecs [21];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        //            rst sv data  sl mr | s_rdy m_v data  ml me ok runt
        vecs[0]  = mk(1, 1, 8'hAA, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'h10, 0, 0,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 8'h11, 0, 0,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 8'h12, 0, 0,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 8'h13, 0, 0,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 8'h14, 0, 0,   1,  1, 8'h10, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 8'h15, 1, 0,   0,  1, 8'h10, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 8'h15, 1, 1,   1,  1, 8'h11, 1, 1, 0, 1);
        vecs[8]  = mk(0, 0, 8'h00, 0, 0,   1,  1, 8'h11, 1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 8'h00, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 8'h20, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 8'h21, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 8'h22, 1, 1,   1,  0, 8'h00, 0, 0, 0, 1);
        vecs[13] = mk(0, 0, 8'h00, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 8'h30, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[15] = mk(0, 1, 8'h31, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[16] = mk(0, 1, 8'h32, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[17] = mk(0, 1, 8'h33, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);
        vecs[18] = mk(0, 1, 8'h34, 0, 0,   1,  1, 8'h30, 0, 0, 0, 0);
        vecs[19] = mk(1, 1, 8'h35, 0, 0,   0,  0, 8'h00, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 8'h00, 0, 1,   1,  0, 8'h00, 0, 0, 0, 0);

        repeat (3) @(negedge clk);

        // ---- vector table ----
        foreach (vecs[i]) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            s_last  = vecs[i].sl;
            tbl_mr  = vecs[i].mr;
            #1;
            check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
            if (vecs[i].e_mv || vecs[i].rst)
                check($sformatf("vec%0d_beat", i), 32'({m_data, m_last, m_err}),
                      32'({vecs[i].e_md, vecs[i].e_ml, vecs[i].e_me}));
            check($sformatf("vec%0d_stat_ok", i), 32'(stat_ok), 32'(vecs[i].e_ok));
            check($sformatf("vec%0d_stat_runt", i), 32'(stat_runt), 32'(vecs[i].e_runt));
        end

        @(negedge clk);
        mr_mode = 0;
        mon_en  = 1;

        // ---- good 64-byte frame, latency of first output ----
        build_frame(60, 0);
        first_pending = 1;
        send_frame(0);
        drain();
        check("first_out_latency", 32'(first_valid_cyc), 32'(accept5_cyc + 1));

        // ---- same frame with FCS bit 0 of last byte inverted ----
        build_frame(60, 0);
        frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
        send_frame(0);
        drain();

        // ---- 3-byte frame then good 64-byte frame, back to back ----
        frm.delete();
        frm.push_back(8'hA1);
        frm.push_back(8'hB2);
        frm.push_back(8'hC3);
        send_frame(0);
        build_frame(60, 1);
        send_frame(0);
        drain();

        // ---- 20-byte frame with valid FCS: runt only ----
        build_frame(16, 1);
        send_frame(0);
        drain();

        // ---- three good frames, toggling m_ready, gapped input ----
        begin
            int ok_before;
            ok_before = ok_count;
            mr_mode = 1;
            for (int f = 0; f < 3; f++) begin
                build_frame(60, 1);
                send_frame(1);
            end
            drain();
            check("three_ok_pulses", 32'(ok_count - ok_before), 32'd3);
        end

        // ---- reset after 30 bytes, then a good frame ----
        mr_mode = 0;
        build_frame(60, 1);
        for (int i = 0; i < 25; i++) exp_q.push_back({frm[i], 1'b0, 1'b0});
        for (int i = 0; i < 30; i++) send_byte(frm[i], 1'b0, 1'b0, i);
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_outputs", 32'({m_valid, m_data, m_last, m_err, stat_ok, stat_crc_err, stat_runt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        build_frame(60, 1);
        send_frame(0);
        drain();

        // ---- randomized frames against the model ----
        mr_mode = 2;
        for (int f = 0; f < 25; f++) begin
            case ($urandom_range(0, 3))
                0: begin
                    frm.delete();
                    for (int i = 0; i < int'($urandom_range(1, 8)); i++) frm.push_back(8'($urandom));
                end
                1: build_frame(int'($urandom_range(60, 70)), 1);
                2: begin
                    int pos;
                    build_frame(int'($urandom_range(60, 70)), 1);
                    pos = int'($urandom_range(0, frm.size() - 1));
                    frm[pos] = frm[pos] ^ (8'h01 << $urandom_range(0, 7));
                end
                default: build_frame(int'($urandom_range(1, 59)), 1);
            endcase
            send_frame(1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_fcs_strip.md
# rx_fcs_strip

Receive-path stage that sits directly downstream of the RX async FIFO read port, in the system clock domain. It consumes the FIFO's byte stream with its end-of-frame flag, computes CRC-32 over each frame, and strips the trailing 4-byte FCS. It forwards payload bytes with an error flag on the final byte. Runt frames are flagged or dropped, and one-cycle status pulses go to the statistics block.

## Interface
Parameters:
- MIN_FRAME, default 64: minimum legal frame length in bytes, FCS included; range 5..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input byte valid (from FIFO rvalid)
- s_ready  out  1  input byte accepted when s_valid && s_ready
- s_data  in  8  input byte
- s_last  in  1  input byte is the final FCS byte of the frame
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- m_data  out  8  payload byte
- m_last  out  1  final payload byte of frame
- m_err  out  1  frame bad (CRC mismatch or runt); meaningful only when m_last=1, else 0
- stat_ok  out  1  one-cycle pulse: good frame completed
- stat_crc_err  out  1  one-cycle pulse: CRC mismatch
- stat_runt  out  1  one-cycle pulse: frame shorter than MIN_FRAME

## Operation
- Delay buffer: 4-byte shift buffer with fill count `fill` (0..4). Each accepted input byte enters the buffer.
  - If fill=4 on accept, the oldest byte is popped into the output register.
  - If fill<4 on accept, fill increments and nothing is emitted.
- s_ready = (fill<4) || !m_valid || m_ready.
- Output register load on a pop:
  - m_data = oldest byte
  - m_last = s_last
  - m_err = s_last && (crc_bad || runt)
- CRC: reflected polynomial 0xEDB88320, LSB-first, register init 0xFFFFFFFF. It covers every input byte including the FCS.
  - crc_next = register updated with the current byte.
  - The frame is good iff crc_next = 0xDEBB20E3 on the s_last byte.
- Length: 16-bit counter of accepted bytes, FCS included. It saturates at 0xFFFF.
  - len_next = counter + 1 (the current byte included).
  - runt = len_next < MIN_FRAME.
- On accept of an s_last byte:
  - fill, CRC and length counter reinitialise (0, 0xFFFFFFFF, 0), so the next byte starts a new frame.
- Frame of ≤4 bytes (s_last accepted while fill<4):
  - No output byte is produced.
  - stat_runt pulses; stat_crc_err pulses if the CRC is also bad.
- Status pulses are registered and asserted the cycle after the s_last accept:
  - stat_ok iff !crc_bad && !runt.
  - stat_crc_err and stat_runt are independent; both may assert together.
- Reset (any time, including mid-frame) sets:
  - m_valid, m_last, m_err and all stat pulses to 0; m_data to 0x00.
  - fill 0, CRC 0xFFFFFFFF, length 0.
  - The first byte accepted after rst deasserts starts a new frame. Any partial frame is lost without a status pulse.

## Timing
- Throughput: 1 byte/cycle sustained with m_ready=1, including back-to-back frames (the next frame's first byte is accepted the cycle after s_last).
- Latency: payload byte k is presented on m_data the cycle after input byte k+4 is accepted. The final payload byte appears, with m_last/m_err, the cycle after s_last is accepted.
- Backpressure:
  - While m_valid=1 and m_ready=0, m_data/m_last/m_err are held stable.
  - While fill=4 in that state, s_ready=0.
- s_ready depends combinationally on m_ready. No other comb path from input to output.
- Status pulses are coincident with the m_last beat first being presented. They are not repeated if that beat is stalled.

## Test plan
- 64-byte frame (60 payload bytes 0x00..0x3B + correct FCS), m_ready=1 → 60 bytes out in order; m_last and m_err=0 on byte 0x3B; stat_ok single pulse; first output 1 cycle after 5th input accept.
- Same frame with FCS bit 0 of the last byte inverted → identical 60 bytes; m_err=1 on the last beat; stat_crc_err pulse, stat_ok=0.
- 3-byte frame (s_last on byte 3) followed by a good 64-byte frame → no output for the first frame and stat_runt pulse; the second frame is emitted correct with stat_ok.
- 20-byte frame with valid FCS, MIN_FRAME=64 → 16 payload bytes; m_err=1 on the last; stat_runt=1, stat_crc_err=0.
- Three back-to-back 64-byte good frames with m_ready toggling 1,0,1,0… and s_valid randomly gapped → 180 bytes in order, no loss or duplication; outputs stable during stalls; exactly 3 stat_ok pulses.
- rst asserted for 1 cycle after 30 bytes of a frame, then a complete good 64-byte frame → all outputs 0 during/after reset; the new frame is emitted cleanly with stat_ok; no status pulse for the aborted frame.
